// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: pipeline control/request structs, the
// FetchInfo payload handed to decode, and the instruction-queue entry.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    // {enable, pc, inst} registered towards decode
    typedef struct packed {
        logic            enable;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } FetchInfo;

    // Stall/flush from hazard control
    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    // Stall/flush requests a stage raises towards hazard control
    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    // One buffered instruction
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: DEPTH-entry FIFO of {pc, inst}.
// Ports:
//   clk, rst      clock, async active-high reset
//   push_i        write push_data_i at the tail
//   pop_i         drop the head entry
//   clear_i       empty the queue (wins over push/pop)
//   push_data_i   entry to write
//   head_o        current head entry (valid when !empty_o)
//   count_o       number of stored entries
//   empty_o       queue is empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  fetch_entry_t     push_data_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset: entries are only read once counted
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch.sv
// IF stage: issues in-order word requests to instruction memory, buffers the
// responses and hands {enable, pc, inst} to decode. Responses belonging to a
// path abandoned by an EX redirect are counted and dropped.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect target
// raises a sticky error and halts fetch until an aligned redirect).
// Ports:
//   clk, rst         clock, async active-high reset
//   pipe             stall/flush from hazard control
//   req              stage requests (fetch never requests: all zero)
//   redirect_valid   EX resolved taken branch/jump this cycle
//   redirect_pc      new fetch target
//   imem_req_valid   request valid (held with address until accepted)
//   imem_req_ready   memory accepts request
//   imem_req_addr    word-aligned byte address
//   imem_resp_valid  in-order response, latency >= 1, never backpressured
//   imem_resp_data   instruction word
//   fetch_info       registered {enable, pc, inst} to decode
//   error            misaligned redirect target (feature build only, else 0)
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  PipeControl      pipe,
    output PipeRequest      req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output FetchInfo        fetch_info,
    output logic            error
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_next_q,   pc_next_d;
    logic [XLEN-1:0]  resp_pc_q,   resp_pc_d;
    logic [CNT_W-1:0] inflight_q,  inflight_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
    logic             hold_q,      hold_d;
    logic [XLEN-1:0]  hold_addr_q, hold_addr_d;
    logic             stale_q,     stale_d;
    FetchInfo         fetch_info_q, fetch_info_d;

    logic             halted;
    logic [XLEN-1:0]  redir_target;
    logic [OCC_W-1:0] occupancy;
    logic             cap_ok;
    logic             req_valid_c;
    logic [XLEN-1:0]  req_addr_c;
    logic             accept;

    logic             q_push;
    logic             q_pop;
    logic             q_clear;
    fetch_entry_t     q_push_data;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic error_q, error_d;
    logic redir_bad;
    assign redir_bad    = |redirect_pc[1:0];
    assign redir_target = redirect_pc;
    assign halted       = error_q;
    assign error        = error_q;
`else
    assign redir_target = redirect_pc & ~XLEN'(INST_BYTES - 1);
    assign halted       = 1'b0;
    assign error        = 1'b0;
`endif

    // Issue cap: in-flight plus buffered never exceeds the queue depth, so
    // every response always has room and needs no backpressure.
    assign occupancy   = {1'b0, inflight_q} + {1'b0, q_count};
    assign cap_ok      = occupancy < OCC_W'(BUF_DEPTH);
    assign req_valid_c = !rst && (hold_q || (cap_ok && !halted));
    assign req_addr_c  = hold_q ? hold_addr_q : pc_next_q;
    assign accept      = req_valid_c && imem_req_ready;

    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = req_addr_c;
    assign req            = '{stall_req: 1'b0, flush_req: 4'b0000};
    assign fetch_info     = fetch_info_q;

    assign q_push_data.pc   = resp_pc_q;
    assign q_push_data.inst = imem_resp_data;

    fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (q_push),
        .pop_i       (q_pop),
        .clear_i     (q_clear),
        .push_data_i (q_push_data),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty)
    );

    // Next-state: request channel, response bookkeeping, redirect, output reg
    always_comb begin
        pc_next_d    = pc_next_q;
        resp_pc_d    = resp_pc_q;
        inflight_d   = inflight_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
        drop_cnt_d   = drop_cnt_q;
        hold_d       = hold_q;
        hold_addr_d  = hold_addr_q;
        stale_d      = stale_q;
        fetch_info_d = fetch_info_q;
        q_push       = 1'b0;
        q_pop        = 1'b0;
        q_clear      = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        error_d      = error_q;
`endif

        // A raised request keeps its address until accepted
        if (req_valid_c && !imem_req_ready) begin
            hold_d      = 1'b1;
            hold_addr_d = req_addr_c;
        end else if (accept) begin
            hold_d  = 1'b0;
            stale_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_next_d  = redir_target;
            resp_pc_d  = redir_target;
            q_clear    = 1'b1;
            // Everything still outstanding after this edge is wrong-path;
            // a response arriving now is simply not pushed.
            drop_cnt_d = inflight_d;
            // A request left pending across the redirect is wrong-path too
            stale_d    = req_valid_c && !imem_req_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
            error_d    = redir_bad;
`endif
        end else begin
            // A stale accept carries an old address and must not advance the PC
            if (accept && !stale_q) pc_next_d = next_pc(pc_next_q);
            if (imem_resp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    q_push    = 1'b1;
                    resp_pc_d = next_pc(resp_pc_q);
                end
            end
            if (accept && stale_q) drop_cnt_d = drop_cnt_d + CNT_W'(1);
        end

        // Output register: flush > stall > load head > idle
        if (pipe.flush) begin
            fetch_info_d.enable = 1'b0;
        end else if (!pipe.stall) begin
            if (!q_empty && !halted) begin
                fetch_info_d.enable = 1'b1;
                fetch_info_d.pc     = q_head.pc;
                fetch_info_d.inst   = q_head.inst;
                q_pop               = 1'b1;
            end else begin
                fetch_info_d.enable = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_next_q    <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            hold_q       <= 1'b0;
            hold_addr_q  <= '0;
            stale_q      <= 1'b0;
            fetch_info_q <= '0;
        end else begin
            pc_next_q    <= pc_next_d;
            resp_pc_q    <= resp_pc_d;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            hold_q       <= hold_d;
            hold_addr_q  <= hold_addr_d;
            stale_q      <= stale_d;
            fetch_info_q <= fetch_info_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order instruction memory model with random latency and
// ready, plus a program-order reference of the instruction stream decode sees.
`timescale 1ns/1ps
module tb_fetch;
    import fetch_pkg::*;

    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    PipeControl  pipe;
    PipeRequest  req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    FetchInfo    fetch_info;
    logic        error;

    fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe            (pipe),
        .req             (req),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fetch_info      (fetch_info),
        .error           (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model: accepted requests answered in order after a random latency
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    int          cyc      = 0;
    int          last_due = -1;
    int          lat_lo   = 1;
    int          lat_hi   = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    // Reference: next PC decode must see, in program order
    logic [31:0] exp_pc    = RESET_PC;
    int          delivered = 0;
    bit          err_exp   = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    // One clock: drive inputs at the negedge, advance, then check outputs
    task automatic step(input bit rdy, input bit stl, input bit fl, input bit rv, input logic [31:0] rpc);
        FetchInfo    prev_fi;
        bit          acc;
        bit          bad;
        int          d;
        logic [31:0] tgt;
        if (prev_pend) begin
            check("req_hold_valid", 96'(imem_req_valid), 96'(1));
            check("req_hold_addr", 96'(imem_req_addr), 96'(prev_addr));
        end
        imem_req_ready = rdy;
        pipe.stall     = stl;
        pipe.flush     = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        acc = imem_req_valid && rdy;
        if (acc) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: imem_req_addr, due: d});
            acc_log.push_back(imem_req_addr);
            check("outstanding_cap", 96'(mq.size() <= BUF_DEPTH), 96'(1));
        end
        prev_pend = imem_req_valid && !rdy;
        prev_addr = imem_req_addr;
        prev_fi   = fetch_info;
        @(posedge clk);
        cyc++;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        tgt = rpc;
        bad = (rpc[1:0] != 2'b00);
`else
        tgt = {rpc[31:2], 2'b00};
        bad = 1'b0;
`endif
        if (rv) err_exp = bad;
        check("error", 96'(error), 96'(err_exp));
        if (fl) begin
            check("flush_clears_enable", 96'(fetch_info.enable), 96'(0));
        end else if (stl) begin
            check("stall_holds", 96'(fetch_info), 96'(prev_fi));
        end else if (fetch_info.enable) begin
            check("stream_pc", 96'(fetch_info.pc), 96'(exp_pc));
            check("stream_inst", 96'(fetch_info.inst), 96'(mem_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (err_exp) check("halted_no_enable", 96'(fetch_info.enable), 96'(0));
        if (rv) exp_pc = tgt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          d0;
        int          n0;
        int          guard;
        bit          r_rv;
        bit          r_fl;
        logic [31:0] r_pc;
        logic [31:0] held;

        rst             = 1'b1;
        pipe            = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_fetch_info", 96'(fetch_info), 96'(0));
        check("rst_req_valid", 96'(imem_req_valid), 96'(0));
        check("rst_error", 96'(error), 96'(0));
        check("rst_pipe_req", 96'(req), 96'(0));
        rst = 1'b0;
        #1;
        check("first_req_valid", 96'(imem_req_valid), 96'(1));
        check("first_req_addr", 96'(imem_req_addr), 96'(RESET_PC));

        // Test 1: ready=1, latency 1 -> first instruction three cycles after reset
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, 0, '0);
        check("t1_en_c1", 96'(fetch_info.enable), 96'(0));
        step(1, 0, 0, 0, '0);
        check("t1_en_c2", 96'(fetch_info.enable), 96'(0));
        step(1, 0, 0, 0, '0);
        check("t1_en_c3", 96'(fetch_info.enable), 96'(1));
        check("t1_pc_c3", 96'(fetch_info.pc), 96'(RESET_PC));
        repeat (3) step(1, 0, 0, 0, '0);
        check("t1_addr0", 96'(acc_log[0]), 96'(32'h0));
        check("t1_addr1", 96'(acc_log[1]), 96'(32'h4));
        check("t1_addr2", 96'(acc_log[2]), 96'(32'h8));

        // Test 2: five-cycle stall fills the queue and stops issue
        repeat (6) step(1, 0, 0, 0, '0);
        d0 = delivered;
        repeat (5) step(1, 1, 0, 0, '0);
        check("t2_valid_drops", 96'(imem_req_valid), 96'(0));
        repeat (15) step(1, 0, 0, 0, '0);
        check("t2_resumes", 96'(delivered >= d0 + 4), 96'(1));

        // Test 3: redirect with two requests in flight
        lat_lo = 3; lat_hi = 3;
        guard = 0;
        while (mq.size() != 2 && guard < 20) begin
            step(1, 0, 0, 0, '0);
            guard++;
        end
        check("t3_two_inflight", 96'(mq.size()), 96'(2));
        step(1, 0, 1, 1, 32'h100);
        d0 = delivered;
        repeat (15) step(1, 0, 0, 0, '0);
        check("t3_target_fetched", 96'(delivered > d0), 96'(1));

        // Test 4: request held unaccepted across a redirect
        lat_lo = 1; lat_hi = 1;
        guard = 0;
        while (!imem_req_valid && guard < 20) begin
            step(1, 0, 0, 0, '0);
            guard++;
        end
        check("t4_valid_up", 96'(imem_req_valid), 96'(1));
        held = imem_req_addr;
        repeat (3) step(0, 0, 0, 0, '0);
        step(0, 0, 1, 1, 32'h100);
        step(0, 0, 0, 0, '0);
        n0 = acc_log.size();
        d0 = delivered;
        repeat (15) step(1, 0, 0, 0, '0);
        check("t4_stale_accept", 96'(acc_log[n0]), 96'(held));
        check("t4_new_path", 96'(acc_log[n0 + 1]), 96'(32'h100));
        check("t4_target_fetched", 96'(delivered > d0), 96'(1));

        // Test 5: response and redirect on the same edge
        lat_lo = 2; lat_hi = 2;
        guard = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc) && guard < 20) begin
            step(1, 0, 0, 0, '0);
            guard++;
        end
        check("t5_resp_due", 96'(mq.size() > 0 && mq[0].due <= cyc), 96'(1));
        step(1, 0, 1, 1, 32'h300);
        d0 = delivered;
        repeat (15) step(1, 0, 0, 0, '0);
        check("t5_target_fetched", 96'(delivered > d0), 96'(1));

`ifdef FETCH_MISALIGN_CHECK_EN
        // Test 6: misaligned redirect halts, aligned redirect resumes
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 1, 1, 32'h102);
        repeat (2) step(1, 0, 0, 0, '0);
        n0 = acc_log.size();
        repeat (6) step(1, 0, 0, 0, '0);
        check("t6_no_requests", 96'(acc_log.size()), 96'(n0));
        check("t6_valid_low", 96'(imem_req_valid), 96'(0));
        step(1, 0, 1, 1, 32'h200);
        d0 = delivered;
        repeat (10) step(1, 0, 0, 0, '0);
        check("t6_addr_200", 96'(acc_log[n0]), 96'(32'h200));
        check("t6_resumed", 96'(delivered > d0), 96'(1));
`endif

        // Random phase
        lat_lo = 1; lat_hi = 4;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            r_rv = ($urandom_range(39, 0) == 0);
            r_fl = r_rv || ($urandom_range(29, 0) == 0);
            r_pc = {20'h0, 10'($urandom_range(1023, 0)), 2'($urandom_range(3, 0))};
`ifdef FETCH_MISALIGN_CHECK_EN
            r_pc[1:0] = 2'b00;
`endif
            step($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0, r_fl, r_rv, r_pc);
        end
        check("random_progress", 96'(delivered > d0 + 100), 96'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
